// File: rtl/serial_out_scheduler.sv
// Command scheduler for a bank of serial_out channels.
// Holds per-channel shadow registers (pattern, frequency, mode), tracks busy
// and pending channels, and issues one-cycle start/stop pulses either to one
// channel or to every pending channel at once (SYNC).
//
// Command handshake: a command is transferred on a clock edge where
// i_cmd_valid and o_cmd_ready are both high. o_cmd_ready is high only while
// the scheduler is idle; i_cmd_valid without o_cmd_ready is dropped, not held.
// Every transferred command ends with exactly one o_done_tick (accepted) or
// one o_err_tick (rejected), three cycles after the transfer cycle.
module serial_out_scheduler #(
   parameter int DATA_BIT = 32,
   parameter int CH_NUM   = 2,
   parameter int SEL_BIT  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_cmd_valid,
   input  logic [1:0]                   i_cmd_op,
   input  logic [SEL_BIT-1:0]           i_sel,
   input  logic [DATA_BIT-1:0]          i_output_pattern,
   input  logic [DATA_BIT-1:0]          i_freq_pattern,
   input  logic                         i_mode,
   input  logic [CH_NUM-1:0]            i_ch_done_tick,
   output logic                         o_cmd_ready,
   output logic [CH_NUM*DATA_BIT-1:0]   o_output_pattern,
   output logic [CH_NUM*DATA_BIT-1:0]   o_freq_pattern,
   output logic [CH_NUM-1:0]            o_mode,
   output logic [CH_NUM-1:0]            o_start,
   output logic [CH_NUM-1:0]            o_stop,
   output logic [CH_NUM-1:0]            o_busy,
   output logic [CH_NUM-1:0]            o_pending,
   output logic                         o_done_tick,
   output logic                         o_err_tick,
   output logic [1:0]                   dbg_state
);

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_START = 2'd1;
   localparam logic [1:0] OP_STOP  = 2'd2;
   localparam logic [1:0] OP_SYNC  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_next;
   logic                  accept;

   // Registered command
   logic [1:0]            op;
   logic [SEL_BIT-1:0]    sel;
   logic [DATA_BIT-1:0]   pat;
   logic [DATA_BIT-1:0]   freq;
   logic                  mode;

   // Outcome of the check, carried into the issue cycle
   logic                  ok;
   logic [CH_NUM-1:0]     mask;

   logic [CH_NUM-1:0]     busy;
   logic [CH_NUM-1:0]     pending;
   logic [CH_NUM-1:0]     busy_next;
   logic [CH_NUM-1:0]     pending_next;

   logic [CH_NUM-1:0]     sel_mask;
   logic                  sel_ok;
   logic                  sel_busy;
   logic                  check_ok;
   logic [CH_NUM-1:0]     check_mask;

   assign o_busy    = busy;
   assign o_pending = pending;
   assign dbg_state = state;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Fixed four-cycle walk per command; ready only while idle
   always_comb begin
      state_next  = state;
      o_cmd_ready = 1'b0;
      accept      = 1'b0;
      case (state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               accept     = 1'b1;
               state_next = S_LOAD;
            end
         end
         S_LOAD:  state_next = S_ISSUE;
         S_ISSUE: state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Latch the command fields on transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         op   <= '0;
         sel  <= '0;
         pat  <= '0;
         freq <= '0;
         mode <= 1'b0;
      end else if (accept) begin
         op   <= i_cmd_op;
         sel  <= i_sel;
         pat  <= i_output_pattern;
         freq <= i_freq_pattern;
         mode <= i_mode;
      end
   end

   // Validity check against the registered busy/pending state
   always_comb begin
      sel_mask = '0;
      for (int k = 0; k < CH_NUM; k++) sel_mask[k] = (sel == SEL_BIT'(k));
      // a select beyond the channel count matches no channel
      sel_ok     = |sel_mask;
      sel_busy   = |(sel_mask & busy);
      check_ok   = 1'b0;
      check_mask = sel_mask;
      case (op)
         OP_LOAD, OP_START: check_ok = sel_ok && !sel_busy;
         OP_STOP:           check_ok = sel_ok;
         default: begin
            check_ok   = 1'b1;
            check_mask = pending;
         end
      endcase
   end

   // Capture the check result; pulses and ticks are registered one cycle each
   always_ff @(posedge clk) begin
      if (rst) begin
         ok          <= 1'b0;
         mask        <= '0;
         o_start     <= '0;
         o_stop      <= '0;
         o_done_tick <= 1'b0;
         o_err_tick  <= 1'b0;
      end else begin
         o_start     <= '0;
         o_stop      <= '0;
         o_done_tick <= 1'b0;
         o_err_tick  <= 1'b0;
         if (state == S_LOAD) begin
            ok   <= check_ok;
            mask <= check_ok ? check_mask : '0;
            if (check_ok && (op == OP_START || op == OP_SYNC)) o_start <= check_mask;
            if (check_ok && op == OP_STOP)                     o_stop  <= check_mask;
         end
         if (state == S_ISSUE) begin
            o_done_tick <= ok;
            o_err_tick  <= !ok;
         end
      end
   end

   // Shadow registers: written whole at the end of the check cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         o_output_pattern <= '0;
         o_freq_pattern   <= '0;
         o_mode           <= '0;
      end else if (state == S_LOAD && check_ok && (op == OP_LOAD || op == OP_START)) begin
         for (int k = 0; k < CH_NUM; k++) begin
            if (sel_mask[k]) begin
               o_output_pattern[k*DATA_BIT +: DATA_BIT] <= pat;
               o_freq_pattern[k*DATA_BIT +: DATA_BIT]   <= freq;
               o_mode[k]                                <= mode;
            end
         end
      end
   end

   // Busy/pending update: one-shot done ticks clear busy, a start in the
   // issue cycle overrides a coincident done tick
   always_comb begin
      busy_next    = busy & ~(i_ch_done_tick & ~o_mode);
      pending_next = pending;
      if (state == S_ISSUE && ok) begin
         case (op)
            OP_LOAD: pending_next = pending | mask;
            OP_START, OP_SYNC: begin
               busy_next    = busy_next | mask;
               pending_next = pending & ~mask;
            end
            default: begin
               busy_next    = busy_next & ~mask;
               pending_next = pending & ~mask;
            end
         endcase
      end
   end

   // Busy/pending registers
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= '0;
         pending <= '0;
      end else begin
         busy    <= busy_next;
         pending <= pending_next;
      end
   end

endmodule

// File: tb/tb_serial_out_scheduler.sv
// Bench for serial_out_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// command-level behavioural model.
module tb_serial_out_scheduler;

   localparam int DW = 32;
   localparam int CH = 2;
   localparam int SW = 4;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_START = 2'd1;
   localparam logic [1:0] OP_STOP  = 2'd2;
   localparam logic [1:0] OP_SYNC  = 2'd3;

   logic                clk;
   logic                rst;
   logic                i_cmd_valid;
   logic [1:0]          i_cmd_op;
   logic [SW-1:0]       i_sel;
   logic [DW-1:0]       i_output_pattern;
   logic [DW-1:0]       i_freq_pattern;
   logic                i_mode;
   logic [CH-1:0]       i_ch_done_tick;
   logic                o_cmd_ready;
   logic [CH*DW-1:0]    o_output_pattern;
   logic [CH*DW-1:0]    o_freq_pattern;
   logic [CH-1:0]       o_mode;
   logic [CH-1:0]       o_start;
   logic [CH-1:0]       o_stop;
   logic [CH-1:0]       o_busy;
   logic [CH-1:0]       o_pending;
   logic                o_done_tick;
   logic                o_err_tick;
   logic [1:0]          dbg_state;

   serial_out_scheduler #(.DATA_BIT(DW), .CH_NUM(CH), .SEL_BIT(SW)) dut (
      .clk(clk), .rst(rst),
      .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op), .i_sel(i_sel),
      .i_output_pattern(i_output_pattern), .i_freq_pattern(i_freq_pattern),
      .i_mode(i_mode), .i_ch_done_tick(i_ch_done_tick),
      .o_cmd_ready(o_cmd_ready), .o_output_pattern(o_output_pattern),
      .o_freq_pattern(o_freq_pattern), .o_mode(o_mode),
      .o_start(o_start), .o_stop(o_stop), .o_busy(o_busy), .o_pending(o_pending),
      .o_done_tick(o_done_tick), .o_err_tick(o_err_tick), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // age: -1 idle, 1 check cycle, 2 issue cycle, 3 completion cycle
   int             age;
   logic [1:0]     m_op;
   int             m_sel;
   logic [DW-1:0]  m_pat_in, m_freq_in;
   logic           m_mode_in;
   logic           m_ok;
   logic [CH-1:0]  m_mask;
   logic [CH-1:0]  m_busy, m_pending;
   logic [DW-1:0]  m_pat [CH];
   logic [DW-1:0]  m_freq[CH];
   logic           m_mode[CH];

   task automatic model_reset();
      age = -1; m_op = 0; m_sel = 0; m_ok = 0; m_mask = 0;
      m_busy = 0; m_pending = 0;
      for (int k = 0; k < CH; k++) begin
         m_pat[k] = 0; m_freq[k] = 0; m_mode[k] = 0;
      end
   endtask

   initial model_reset();

   always @(posedge clk) begin
      logic [CH-1:0] nb, np;
      if (rst) model_reset();
      else begin
         nb = m_busy;
         np = m_pending;
         for (int k = 0; k < CH; k++)
            if (i_ch_done_tick[k] && !m_mode[k]) nb[k] = 1'b0;
         case (age)
            -1: if (i_cmd_valid) begin
               m_op = i_cmd_op; m_sel = int'(i_sel);
               m_pat_in = i_output_pattern; m_freq_in = i_freq_pattern;
               m_mode_in = i_mode;
               age = 1;
            end
            1: begin
               bit in_range;
               in_range = (m_sel < CH);
               if (m_op == OP_SYNC) begin
                  m_ok = 1'b1; m_mask = m_pending;
               end else begin
                  m_mask = in_range ? CH'(1 << m_sel) : '0;
                  if (m_op == OP_STOP) m_ok = in_range;
                  else                 m_ok = in_range && !m_busy[m_sel];
               end
               if (!m_ok) m_mask = '0;
               if (m_ok && (m_op == OP_LOAD || m_op == OP_START)) begin
                  m_pat[m_sel] = m_pat_in; m_freq[m_sel] = m_freq_in;
                  m_mode[m_sel] = m_mode_in;
               end
               age = 2;
            end
            2: begin
               if (m_ok) begin
                  if (m_op == OP_LOAD) np = np | m_mask;
                  else if (m_op == OP_STOP) begin
                     nb = nb & ~m_mask; np = np & ~m_mask;
                  end else begin
                     nb = nb | m_mask; np = np & ~m_mask;
                  end
               end
               age = 3;
            end
            default: age = -1;
         endcase
         m_busy = nb;
         m_pending = np;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [CH*DW-1:0] e_pat, e_freq;
         logic [CH-1:0]    e_mode, e_start, e_stop;
         for (int k = 0; k < CH; k++) begin
            e_pat[k*DW +: DW]  = m_pat[k];
            e_freq[k*DW +: DW] = m_freq[k];
            e_mode[k]          = m_mode[k];
         end
         e_start = (age == 2 && m_ok && (m_op == OP_START || m_op == OP_SYNC)) ? m_mask : '0;
         e_stop  = (age == 2 && m_ok && m_op == OP_STOP) ? m_mask : '0;
         chk("cmp_ready",   64'(o_cmd_ready), 64'(age == -1));
         chk("cmp_start",   64'(o_start),     64'(e_start));
         chk("cmp_stop",    64'(o_stop),      64'(e_stop));
         chk("cmp_done",    64'(o_done_tick), 64'(age == 3 && m_ok));
         chk("cmp_err",     64'(o_err_tick),  64'(age == 3 && !m_ok));
         chk("cmp_busy",    64'(o_busy),      64'(m_busy));
         chk("cmp_pending", 64'(o_pending),   64'(m_pending));
         chk("cmp_pattern", 64'(o_output_pattern), 64'(e_pat));
         chk("cmp_freq",    64'(o_freq_pattern),   64'(e_freq));
         chk("cmp_mode",    64'(o_mode),      64'(e_mode));
      end
   end

   // ---------------- driver tasks ----------------
   logic [CH-1:0] cap_start, cap_stop;
   logic          cap_done, cap_err;
   logic [DW-1:0] cap_pat0;

   task automatic wait_ready();
      int n = 0;
      while (!o_cmd_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!o_cmd_ready) chk("ready_timeout", 64'(o_cmd_ready), 64'd1);
   endtask

   task automatic set_cmd(input logic [1:0] op, input logic [SW-1:0] sel,
                          input logic [DW-1:0] pat, input logic [DW-1:0] freq,
                          input logic mode);
      i_cmd_valid = 1'b1; i_cmd_op = op; i_sel = sel;
      i_output_pattern = pat; i_freq_pattern = freq; i_mode = mode;
   endtask

   // Full command from idle back to idle; dt_issue is a done tick driven
   // during the issue cycle
   task automatic run_cmd(input logic [1:0] op, input logic [SW-1:0] sel,
                          input logic [DW-1:0] pat, input logic [DW-1:0] freq,
                          input logic mode, input logic [CH-1:0] dt_issue);
      wait_ready();
      set_cmd(op, sel, pat, freq, mode);
      @(negedge clk);
      i_cmd_valid = 1'b0;
      @(negedge clk);
      i_ch_done_tick = dt_issue;
      cap_start = o_start; cap_stop = o_stop; cap_pat0 = o_output_pattern[DW-1:0];
      @(negedge clk);
      i_ch_done_tick = '0;
      cap_done = o_done_tick; cap_err = o_err_tick;
      @(negedge clk);
   endtask

   task automatic tick(input logic [CH-1:0] m);
      i_ch_done_tick = m;
      @(negedge clk);
      i_ch_done_tick = '0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n_done, n_err;
      logic [CH-1:0] any_start;
      rst = 1'b1; i_cmd_valid = 0; i_cmd_op = 0; i_sel = 0;
      i_output_pattern = 0; i_freq_pattern = 0; i_mode = 0; i_ch_done_tick = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("reset_ready", 64'(o_cmd_ready), 64'd1);
      chk("reset_busy",  64'(o_busy), 64'd0);

      // single START with one-shot done
      run_cmd(OP_START, 0, 32'hA5A5_0F0F, 32'h0000_FFFF, 1'b0, 2'b00);
      chk("t1_start", 64'(cap_start), 64'h1);
      chk("t1_pat",   64'(cap_pat0), 64'hA5A5_0F0F);
      chk("t1_done",  64'(cap_done), 64'd1);
      chk("t1_busy",  64'(o_busy), 64'h1);
      tick(2'b01);
      chk("t1_busy_clr", 64'(o_busy), 64'h0);

      // LOAD, LOAD, SYNC
      run_cmd(OP_LOAD, 0, 32'h1111_1111, 32'h0, 1'b0, 2'b00);
      run_cmd(OP_LOAD, 1, 32'h2222_2222, 32'h0, 1'b0, 2'b00);
      chk("t2_pending", 64'(o_pending), 64'h3);
      run_cmd(OP_SYNC, 0, 32'h0, 32'h0, 1'b0, 2'b00);
      chk("t2_start", 64'(cap_start), 64'h3);
      chk("t2_busy",  64'(o_busy), 64'h3);
      chk("t2_pend0", 64'(o_pending), 64'h0);
      tick(2'b11);
      chk("t2_busy_clr", 64'(o_busy), 64'h0);

      // repeat-mode channel rejects rewrite, ignores done, stops on STOP
      run_cmd(OP_START, 1, 32'h3333_3333, 32'h0, 1'b1, 2'b00);
      run_cmd(OP_LOAD, 1, 32'h4444_4444, 32'h0, 1'b0, 2'b00);
      chk("t3_err",    64'(cap_err), 64'd1);
      chk("t3_nodone", 64'(cap_done), 64'd0);
      chk("t3_shadow", 64'(o_output_pattern[2*DW-1:DW]), 64'h3333_3333);
      tick(2'b10);
      chk("t3_busy_rep", 64'(o_busy), 64'h2);
      run_cmd(OP_STOP, 1, 32'h0, 32'h0, 1'b0, 2'b00);
      chk("t3_stop", 64'(cap_stop), 64'h2);
      chk("t3_busy", 64'(o_busy), 64'h0);

      // out-of-range select
      run_cmd(OP_START, 5, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00);
      chk("t4_err",   64'(cap_err), 64'd1);
      chk("t4_start", 64'(cap_start), 64'h0);

      // valid while not ready is dropped
      wait_ready();
      set_cmd(OP_LOAD, 0, 32'h5555_5555, 32'h0, 1'b0);
      @(negedge clk);
      chk("t4_notready", 64'(o_cmd_ready), 64'd0);
      set_cmd(OP_START, 0, 32'h6666_6666, 32'h0, 1'b0);
      @(negedge clk);
      i_cmd_valid = 1'b0;
      n_done = 0; n_err = 0; any_start = 0;
      repeat (7) begin
         n_done += int'(o_done_tick); n_err += int'(o_err_tick);
         any_start |= o_start;
         @(negedge clk);
      end
      chk("t4_done_cnt", 64'(n_done), 64'd1);
      chk("t4_err_cnt",  64'(n_err), 64'd0);
      chk("t4_nostart",  64'(any_start), 64'h0);
      chk("t4_pending",  64'(o_pending), 64'h1);
      chk("t4_shadow",   64'(o_output_pattern[DW-1:0]), 64'h5555_5555);

      // done tick coincident with start issue: start wins
      run_cmd(OP_START, 0, 32'h7777_7777, 32'h0, 1'b0, 2'b01);
      chk("t5_start", 64'(cap_start), 64'h1);
      chk("t5_busy",  64'(o_busy), 64'h1);
      run_cmd(OP_STOP, 0, 32'h0, 32'h0, 1'b0, 2'b00);
      chk("t5_stop_busy", 64'(o_busy), 64'h0);

      // reset during SYNC issue
      run_cmd(OP_LOAD, 0, 32'h8888_8888, 32'h0, 1'b0, 2'b00);
      run_cmd(OP_LOAD, 1, 32'h9999_9999, 32'h0, 1'b0, 2'b00);
      wait_ready();
      set_cmd(OP_SYNC, 0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      i_cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_ready",   64'(o_cmd_ready), 64'd1);
      chk("t6_busy",    64'(o_busy), 64'h0);
      chk("t6_pending", 64'(o_pending), 64'h0);
      chk("t6_pattern", 64'(o_output_pattern), 64'h0);
      any_start = 0;
      repeat (4) begin
         any_start |= o_start | o_stop;
         @(negedge clk);
      end
      chk("t6_nopulse", 64'(any_start), 64'h0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         i_cmd_valid      = ($urandom_range(0, 2) == 0);
         i_cmd_op         = 2'($urandom_range(0, 3));
         i_sel            = SW'($urandom_range(0, 3));
         i_output_pattern = $urandom;
         i_freq_pattern   = $urandom;
         i_mode           = 1'($urandom_range(0, 1));
         for (int k = 0; k < CH; k++) i_ch_done_tick[k] = ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      i_cmd_valid = 1'b0;
      i_ch_done_tick = '0;
      repeat (6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
